// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Desc     : Five-stage pipeline hazard/stall controller: load-use bubbles,
//            taken-branch flushes and memory-wait freeze with sticky timeout.
// Options  : HAZ_PERF_CNT_EN adds saturating stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REG_ADDR_W-1:0]             id_reg1_addr,
    input  logic [REG_ADDR_W-1:0]             id_reg2_addr,
    input  logic [REG_ADDR_W-1:0]             id_sw_addr,
    input  logic                              id_reg1_read,
    input  logic                              id_reg2_read,
    input  logic                              id_sw_read,
    input  logic [REG_ADDR_W-1:0]             exe_write_addr,
    input  logic                              exe_reg_write,
    input  logic                              exe_DM_read,
    input  logic                              exe_br_taken,
    input  logic                              mem_dm_req,
    input  logic                              mem_dm_ack,
    output logic                              pc_hold,
    output logic                              ifid_hold,
    output logic                              ifid_flush,
    output logic                              idexe_hold,
    output logic                              idexe_bubble,
    output logic                              exemem_hold,
    output logic                              memwb_bubble,
    output logic [$clog2(MAX_WAIT+1)-1:0]     wait_cnt,
    output logic                              err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]                       perf_stall_cnt,
    output logic [31:0]                       perf_flush_cnt
`endif
);

    localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;

    logic w_mw;
    logic w_lu;
    logic w_br;
    logic w_freeze;

    assign w_mw = mem_dm_req & ~mem_dm_ack;
    assign w_br = exe_br_taken;
    assign w_lu = exe_DM_read & exe_reg_write &
                  ((id_reg1_read & (id_reg1_addr == exe_write_addr)) |
                   (id_reg2_read & (id_reg2_addr == exe_write_addr)) |
                   (id_sw_read   & (id_sw_addr   == exe_write_addr)));

    assign w_freeze = (r_state == ST_ERR) | w_mw;

    // RUN always carries a zero count, so the last-count test also covers MAX_WAIT == 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN, ST_MWAIT: begin
                    if (w_mw) begin
                        if (r_wait_cnt == c_CNT_LAST) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_state    <= ST_MWAIT;
                            r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
                        end
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end
                end
                ST_ERR: begin
                    if (!w_mw) begin
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign wait_cnt = r_wait_cnt;
    assign err      = (r_state == ST_ERR);

    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idexe_hold   = 1'b0;
        idexe_bubble = 1'b0;
        exemem_hold  = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst) begin
            if (w_freeze) begin
                pc_hold      = 1'b1;
                ifid_hold    = 1'b1;
                idexe_hold   = 1'b1;
                exemem_hold  = 1'b1;
                memwb_bubble = 1'b1;
            end else if (w_br) begin
                ifid_flush   = 1'b1;
                idexe_bubble = 1'b1;
            end else if (w_lu) begin
                pc_hold      = 1'b1;
                ifid_hold    = 1'b1;
                idexe_bubble = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (pc_hold && (r_perf_stall_cnt != 32'hFFFF_FFFF)) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (ifid_flush && (r_perf_flush_cnt != 32'hFFFF_FFFF)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall_cnt;
    assign perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule
`default_nettype wire
